// File: rtl/rng_pcg_bank_if.sv
// Wishbone classic slave bus for the PCG RNG bank.
interface rng_pcg_bank_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/rng_pcg_bank.sv
// Multi-channel PCG32 RNG bank: per-channel 64-bit LCG state and output FIFO, one shared
// multiply-add datapath refilling the FIFOs round-robin, Wishbone register access.
module rng_pcg_bank #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  rng_pcg_bank_if.slave  wb
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [63:0] MultRst = 64'h5851f42d4c957f2d;
  localparam logic [63:0] IncRst  = 64'h14057b7ef767814f;

  function automatic logic [31:0] perm_xshrr(input logic [63:0] s);
    logic [63:0] t;
    logic [31:0] x;
    logic [4:0]  r;
    t = ((s >> 18) ^ s) >> 27;
    x = t[31:0];
    r = s[63:59];
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  function automatic logic [31:0] perm_legacy(input logic [63:0] s);
    return s[31:0] ^ {18'h0, s[63:50]};
  endfunction

  logic [63:0]     state_q [NUM_CH];
  logic [63:0]     mult_q  [NUM_CH];
  logic [63:0]     inc_q   [NUM_CH];
  logic [31:0]     mem_q   [NUM_CH][FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q  [NUM_CH];
  logic [PtrW-1:0] rptr_q  [NUM_CH];
  logic [CntW-1:0] cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q, mode_q, uf_q;
  logic [ChW-1:0]  rr_q;
  logic            ack_q, hold_q;
  logic [31:0]     rdat_q;

  logic        req, commit, ch_ok;
  logic [3:0]  ch_a, reg_a;
  logic [NUM_CH-1:0] wr_hit, pop, pop_ne, flush, elig, push;
  logic        gen_valid;
  logic [ChW-1:0] gen_ch;
  logic [63:0] sel_s, sel_m, sel_i, next_s;
  logic [31:0] perm_out, rdata;
  logic        unused_sel;

  assign unused_sel = ^wb.sel;

  // hold_q blocks a second ack while the master keeps stb high after the first one.
  assign req    = wb.cyc & wb.stb;
  assign commit = req & ~ack_q & ~hold_q;
  assign ch_a   = wb.adr[7:4];
  assign reg_a  = wb.adr[3:0];
  assign ch_ok  = (wb.adr[31:8] == 24'h0) && ({28'h0, ch_a} < NUM_CH);

  always_comb begin
    wr_hit = '0;
    pop    = '0;
    pop_ne = '0;
    flush  = '0;
    elig   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (commit && ch_ok && ch_a == 4'(c)) begin
        wr_hit[c] = wb.we;
        pop[c]    = ~wb.we && (reg_a == 4'd0);
      end
      pop_ne[c] = pop[c] && (cnt_q[c] != '0);
      flush[c]  = wr_hit[c] && (reg_a == 4'd1 || reg_a == 4'd2 ||
                                (reg_a == 4'd7 && wb.dat_w[2]));
      elig[c]   = en_q[c] && (cnt_q[c] != CntW'(FIFO_DEPTH)) && !wr_hit[c];
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gen_valid = 1'b0;
    gen_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_q) + i) % NUM_CH;
      if (!gen_valid && elig[idx]) begin
        gen_valid = 1'b1;
        gen_ch    = ChW'(idx);
      end
    end
  end

  always_comb begin
    push = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push[c] = gen_valid && (gen_ch == ChW'(c));
    end
  end

  assign sel_s    = state_q[gen_ch];
  assign sel_m    = mult_q[gen_ch];
  assign sel_i    = inc_q[gen_ch];
  assign next_s   = sel_s * sel_m + sel_i;
  assign perm_out = mode_q[gen_ch] ? perm_legacy(sel_s) : perm_xshrr(sel_s);

  always_comb begin
    rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_ok && ch_a == 4'(c)) begin
        case (reg_a)
          4'd0:    rdata = (cnt_q[c] != '0) ? mem_q[c][rptr_q[c]] : 32'h0;
          4'd1:    rdata = state_q[c][63:32];
          4'd2:    rdata = state_q[c][31:0];
          4'd3:    rdata = mult_q[c][63:32];
          4'd4:    rdata = mult_q[c][31:0];
          4'd5:    rdata = inc_q[c][63:32];
          4'd6:    rdata = inc_q[c][31:0];
          4'd7:    rdata = {11'h0, 5'(cnt_q[c]), 7'h0, uf_q[c], 6'h0, mode_q[c], en_q[c]};
          default: rdata = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      hold_q <= 1'b0;
      rdat_q <= 32'h0;
    end else begin
      ack_q  <= commit;
      hold_q <= req & (ack_q | hold_q);
      if (commit) rdat_q <= rdata;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = rdat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= '0;
      en_q   <= '0;
      mode_q <= '0;
      uf_q   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= 64'(c);
        mult_q[c]  <= MultRst;
        inc_q[c]   <= IncRst;
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      if (gen_valid) rr_q <= (32'(gen_ch) == NUM_CH - 1) ? '0 : gen_ch + 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (push[c]) state_q[c] <= next_s;
        if (wr_hit[c]) begin
          case (reg_a)
            4'd1: state_q[c][63:32] <= wb.dat_w;
            4'd2: state_q[c][31:0]  <= wb.dat_w;
            4'd3: mult_q[c][63:32]  <= wb.dat_w;
            4'd4: mult_q[c][31:0]   <= wb.dat_w;
            4'd5: inc_q[c][63:32]   <= wb.dat_w;
            4'd6: inc_q[c][31:0]    <= wb.dat_w;
            4'd7: begin
              en_q[c]   <= wb.dat_w[0];
              mode_q[c] <= wb.dat_w[1];
              if (wb.dat_w[8]) uf_q[c] <= 1'b0;
            end
            default: ;
          endcase
        end
        if (pop[c] && cnt_q[c] == '0) uf_q[c] <= 1'b1;
        // Flush wins over a same-cycle push so the FIFO always ends empty.
        if (flush[c]) begin
          wptr_q[c] <= '0;
          rptr_q[c] <= '0;
          cnt_q[c]  <= '0;
        end else begin
          if (push[c])   wptr_q[c] <= wptr_q[c] + 1'b1;
          if (pop_ne[c]) rptr_q[c] <= rptr_q[c] + 1'b1;
          cnt_q[c] <= cnt_q[c] + CntW'(push[c]) - CntW'(pop_ne[c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= perm_out;
    end
  end

endmodule

// File: tb/tb_rng_pcg_bank.sv
// Directed self-checking bench for rng_pcg_bank (4 channels, 4-deep FIFOs).
module tb_rng_pcg_bank;
  localparam int NCh = 4;
  localparam int Depth = 4;
  localparam logic [63:0] M = 64'h5851f42d4c957f2d;
  localparam logic [63:0] I = 64'h14057b7ef767814f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rng_pcg_bank_if bus ();

  rng_pcg_bank #(.NUM_CH(NCh), .FIFO_DEPTH(Depth)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] m_xshrr(input logic [63:0] s);
    logic [63:0] t;
    logic [63:0] xx;
    t  = ((s >> 18) ^ s) >> 27;
    xx = {t[31:0], t[31:0]} >> s[63:59];
    return xx[31:0];
  endfunction

  function automatic logic [63:0] m_step(input logic [63:0] s);
    return s * M + I;
  endfunction

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q, output int lat);
    bit got;
    got = 0;
    q   = 32'h0;
    lat = 0;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.dat_w = d;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        got = 1;
        q   = bus.dat_r;
        lat = i;
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout adr=%h: got no ack, required ack within 8 cycles", a);
    end
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    int l;
    xfer(1'b1, a, d, q, l);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    int l;
    xfer(1'b0, a, 32'h0, q, l);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    logic [31:0] q;
    int l;
    rd(32'h07, q);
    chk("reset ctrl0", q, 32'h0);
    xfer(1'b0, 32'h00, 32'h0, q, l);
    chk("reset data0 empty", q, 32'h0);
    checks++;
    if (l !== 1) begin
      errors++;
      $display("FAIL read_latency: got %0d required 1", l);
    end
    rd(32'h07, q);
    chk("underflow flag", q, 32'h00000100);
    rd(32'h12, q);
    chk("state_lo ch1", q, 32'h1);
    rd(32'h33, q);
    chk("mult_hi ch3", q, 32'h5851f42d);
    rd(32'h26, q);
    chk("inc_lo ch2", q, 32'hf767814f);
    wr(32'h07, 32'h00000100);
    rd(32'h07, q);
    chk("underflow clear", q, 32'h0);
  endtask

  task automatic test_legacy;
    logic [31:0] q;
    wr(32'h07, 32'h3);
    repeat (10) @(posedge clk);
    rd(32'h00, q);
    chk("legacy pop0", q, 32'h00000000);
    rd(32'h00, q);
    chk("legacy pop1", q, 32'hf767844e);
    rd(32'h07, q);
    checks++;
    if (q[20:16] < 5'(Depth - 2) || q[20:16] > 5'(Depth) || q[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL legacy level after pops: got %h required level %0d..%0d", q, Depth - 2,
               Depth);
    end
    repeat (6) @(posedge clk);
    rd(32'h07, q);
    chk("legacy refill", q, 32'h00040003);
  endtask

  task automatic test_xshrr;
    logic [31:0] q;
    logic [63:0] s;
    wr(32'h07, 32'h0);
    wr(32'h01, 32'h0);
    wr(32'h02, 32'h0);
    rd(32'h07, q);
    chk("state write flush", q, 32'h0);
    wr(32'h07, 32'h1);
    s = 64'h0;
    for (int k = 0; k < 64; k++) begin
      rd(32'h00, q);
      if (k == 1) chk("xshrr hand pop1", q, 32'h602bf3fd);
      chk($sformatf("xshrr pop%0d", k), q, m_xshrr(s));
      s = m_step(s);
    end
  endtask

  task automatic test_all_channels;
    logic [31:0] q;
    wr(32'h07, 32'h0);
    for (int c = 0; c < NCh; c++) begin
      wr(32'((c << 4) | 1), 32'h0);
      wr(32'((c << 4) | 2), 32'(c));
    end
    for (int c = 0; c < NCh; c++) wr(32'((c << 4) | 7), 32'h1);
    repeat (NCh * Depth + 4) @(posedge clk);
    for (int c = 0; c < NCh; c++) begin
      rd(32'((c << 4) | 7), q);
      chk($sformatf("fill level ch%0d", c), q, 32'h00040001);
    end
    for (int c = 0; c < NCh; c++) begin
      rd(32'(c << 4), q);
      chk($sformatf("all ch%0d pop0", c), q, m_xshrr(64'(c)));
      rd(32'(c << 4), q);
      chk($sformatf("all ch%0d pop1", c), q, m_xshrr(m_step(64'(c))));
    end
  endtask

  task automatic test_stb_hold;
    logic [31:0] q;
    int acks;
    wr(32'h17, 32'h0);
    rd(32'h17, q);
    chk("hold level before", q, 32'h00040000);
    acks = 0;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h10;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.ack) acks++;
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(posedge clk);
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL held stb acks: got %0d required 1", acks);
    end
    rd(32'h17, q);
    chk("hold level after", q, 32'h00030000);
  endtask

  task automatic test_unmapped;
    logic [31:0] q;
    rd(32'h00000107, q);
    chk("unmapped high adr", q, 32'h0);
    rd(32'h53, q);
    chk("unmapped channel", q, 32'h0);
    rd(32'h08, q);
    chk("unmapped reg8", q, 32'h0);
    wr(32'h00000113, 32'hdeadbeef);
    rd(32'h13, q);
    chk("unmapped write ignored", q, 32'h5851f42d);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h00;
    @(posedge clk);
    #1;
    chk("mid ack before rst", 32'(bus.ack), 32'h1);
    chk("mid data before rst", bus.dat_r, m_xshrr(m_step(m_step(64'h0))));
    #1 rst = 1'b1;
    #1;
    chk("ack async drop", 32'(bus.ack), 32'h0);
    chk("dat_r async drop", bus.dat_r, 32'h0);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 4'hf;
    bus.adr = 32'h0; bus.dat_w = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_legacy();
    test_xshrr();
    test_all_channels();
    test_stb_hold();
    test_unmapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rng_pcg_bank.md
# rng_pcg_bank

Multi-channel, parametrised PCG random number generator and Wishbone slave, successor to the single-stream LCG RNG. It has NUM_CH independent 64-bit LCG streams, each with its own state, multiplier, increment and output FIFO. One shared multiply-add datapath refills the FIFOs round-robin, one step per cycle. Each channel selects its output permutation: true PCG32 XSH-RR, or the legacy xor-shift of the previous RNG. It sits under user_proj_example in place of the single-stream RNG.

## Interface
- NUM_CH, 4: channel count, 1..16.
- FIFO_DEPTH, 4: entries per channel FIFO, power of two, 2..16.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cyc  in  1  Wishbone cycle.
- stb  in  1  Wishbone strobe.
- we  in  1  write enable.
- sel  in  4  byte selects; ignored, all writes are full 32-bit.
- adr  in  32  word address: [7:4] channel, [3:0] register; adr[31:8] nonzero means unmapped.
- dat_w  in  32  write data.
- dat_r  out  32  registered read data, valid while ack=1.
- ack  out  1  registered single-cycle acknowledge.

## Operation
- Register map, per channel c = adr[7:4]:
  - 0 DATA (RO): pops FIFO c. If empty, returns 0 and sets UNDERFLOW.
  - 1/2 STATE_HI/LO.
  - 3/4 MULT_HI/LO.
  - 5/6 INC_HI/LO.
  - 7 CTRL.
  - Registers 1..6 are RW.
  - Any write to STATE_HI or STATE_LO flushes FIFO c.
- CTRL write: bit0 EN, bit1 MODE (0 XSH-RR, 1 legacy), bit2 FLUSH (self-clearing, empties FIFO c), bit8 = 1 clears UNDERFLOW.
- CTRL read: bit0 EN, bit1 MODE, bit8 UNDERFLOW, [20:16] FIFO level; other bits 0.
- Unmapped accesses (adr[31:8] ≠ 0, c ≥ NUM_CH, register 8..15): acked, read 0, writes ignored.
- Reset values:
  - state_c = c (zero-extended); mult = 64'h5851f42d4c957f2d; inc = 64'h14057b7ef767814f.
  - EN = 0, MODE = 0, UNDERFLOW = 0, all FIFOs empty, rr pointer 0.
  - ack = 0, dat_r = 0.
- Generator step:
  - Eligible channel: EN=1, FIFO not full (pre-pop count), and no Wishbone write to that channel is committing this cycle.
  - Pick the first eligible channel starting from rr, wrapping modulo NUM_CH. Then rr <= chosen+1 mod NUM_CH. No eligible channel means no step and rr holds.
  - Chosen channel: state <= (state*mult + inc) mod 2^64, computed on the low 64 bits of the product. Push perm(old state).
- Permutations of old state s:
  - XSH-RR: x = (((s>>18)^s)>>27)[31:0], r = s[63:59], out = rotate-right(x, r).
  - Legacy: out = s[31:0] ^ {18'h0, s[63:50]}.
- Simultaneous events:
  - Pop and push on the same FIFO: both happen, level unchanged.
  - A Wishbone write to a channel and a generator step of that channel cannot coincide; the write makes the channel ineligible.
  - FLUSH and push on the same cycle: FIFO ends empty.
  - An UNDERFLOW set and a clear in the same cycle cannot coincide (set needs a read, clear needs a write).
- Reset mid-transaction: ack and dat_r drop immediately. The master must restart the transaction.

## Timing
- ack <= cyc & stb & ~ack: high exactly one cycle, on the cycle after the strobe is first seen. No repeat while stb is held through ack.
- Commit happens at the clock edge that raises ack: register write, FIFO pop, flags, and dat_r load.
- Read latency: 1 cycle. A back-to-back strobe gets ack every other cycle.
- Generator: first push one cycle after the EN write commits.
- Throughput: one push per cycle total, across all channels.
- Round-robin: with all FIFOs empty and all channels enabled, each FIFO fills within NUM_CH*FIFO_DEPTH cycles.
- The new value of a register write is visible to the generator from the next cycle.

## Test plan
- Reset, then read CTRL and DATA of channel 0 → CTRL = 0x00000000; DATA = 0 with ack after 1 cycle; a CTRL re-read gives bit8 = 1.
- Channel 0: write CTRL = 0x3 (EN, legacy), wait 10 cycles, pop twice → 0x00000000 then 0xf767844e. CTRL level reads FIFO_DEPTH-2 immediately after, refilling to FIFO_DEPTH.
- Channel 0, XSH-RR: write STATE_HI = 0 and STATE_LO = 0, then EN=1 → first pop 0x00000000. Later pops match a software PCG32 model (mult/inc at reset values) for 64 words.
- Enable all NUM_CH channels simultaneously with state = c → levels never differ by more than 1 during fill, and every FIFO stops at FIFO_DEPTH.
- Hold stb for 5 cycles on DATA → exactly one ack and one pop; the level drops by 1 only.
- Assert rst mid-fill and mid-read → ack and dat_r go 0 asynchronously. All registers return to reset values, and post-reset behaviour matches the first scenario.
